// File: rtl/mealy_seq_detector.sv
// Parametrised serial pattern detector with a zero-latency Mealy match output,
// overlap/non-overlap modes, synchronous clear and a saturating match counter.
module mealy_seq_detector #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter int                   CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             I,
    input  logic             S,
    input  logic             ovl,
    input  logic             clr,
    output logic             Y,
    output logic             Yr,
    output logic             full,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int            VW   = $clog2(PATTERN_W);
    localparam logic [VW-1:0] VMAX = VW'(PATTERN_W - 1);

    logic [PATTERN_W-2:0] hist;
    logic [VW-1:0]        vcnt;
    logic [PATTERN_W-1:0] window;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The candidate window is the stored history with the incoming bit appended;
    // slicing it also yields the next history, which keeps PATTERN_W=2 legal.
    assign window = {hist, I};
    assign full   = (vcnt == VMAX);
    assign Y      = rst_n & ~clr & S & full & (window == PATTERN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist      <= '0;
            vcnt      <= '0;
            match_cnt <= '0;
            Yr        <= 1'b0;
        end else if (clr) begin
            hist      <= '0;
            vcnt      <= '0;
            match_cnt <= '0;
            Yr        <= 1'b0;
        end else begin
            Yr <= Y;
            if (Y) begin
                match_cnt <= sat_inc(match_cnt);
            end
            if (S) begin
                if (Y && !ovl) begin
                    hist <= '0;
                    vcnt <= '0;
                end else begin
                    hist <= window[PATTERN_W-2:0];
                    if (!full) begin
                        vcnt <= vcnt + VW'(1);
                    end
                end
            end
        end
    end

endmodule
